bitop_req_arbiter: RTL and testbench
====================================

// Module: bitop_req_arbiter
// PURPOSE
//   Shares one 64-bit integer bit-manipulation unit (clear/set/get/pass on opa at bit opb) among NUM_REQ requesters.
//   Round-robin arbitration, valid/ready command accept, one operation in flight, registered per-requester response.
//   Sits between the control processors/DMA clients and the bit-op datapath; owns the datapath's enable/operation/operand pins.
// PARAMETERS
//   NUM_REQ   4   number of requesters (2..8)
//   DATA_W    64  operand/result width
//   UNIT_LAT  1   cycles from unit_enable to valid unit_out/unit_sign (1..4)
// PORTS
//   clk             in   1               clock, rising edge
//   reset           in   1               reset, synchronous, active-high
//   req_valid       in   NUM_REQ         command valid per requester
//   req_ready       out  NUM_REQ         one-hot accept; command taken when valid&ready
//   req_op          in   3*NUM_REQ       op per requester: 000 clr, 001 set, 010 get, 011 pass, 1xx reserved
//   req_opa         in   DATA_W*NUM_REQ  operand A per requester
//   req_opb         in   DATA_W*NUM_REQ  bit index per requester
//   resp_valid      out  NUM_REQ         one-hot result valid, held until resp_ready of same bit
//   resp_ready      in   NUM_REQ         result accept per requester
//   resp_data       out  DATA_W          result, shared bus, valid with resp_valid
//   resp_sign       out  1               unit sign (result bit 63), valid with resp_valid
//   resp_err        out  1               error flag, valid with resp_valid (see CONFIGURATION)
//   unit_enable     out  1               one-cycle issue strobe to bit-op unit
//   unit_operation  out  3               latched op to unit
//   unit_opa/opb    out  DATA_W each     latched operands to unit
//   unit_out        in   DATA_W          unit result
//   unit_sign       in   1               unit sign
//   busy            out  1               high in any state except IDLE
// BEHAVIOUR
//   - Reset: FSM=IDLE; req_ready, resp_valid, unit_enable, busy, resp_err = 0; resp_data, unit_* = 0; last_grant=NUM_REQ-1 (req 0 wins first).
//   - Reset mid-operation aborts: in-flight command and pending response discarded, no resp_valid issued.
//   - FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
//   - IDLE: if any req_valid, grant g = first valid index after last_grant (wrapping); req_ready[g]=1 combinationally
//     that cycle only; op/opa/opb of g latched; last_grant<=g; -> ISSUE. req_ready all-zero in every other state.
//   - ISSUE: unit_enable=1 exactly one cycle, unit_operation/opa/opb = latched values (stable from ISSUE through WAIT); -> WAIT.
//   - WAIT: counter from UNIT_LAT-1 down; at count 0 capture unit_out->resp_data, unit_sign->resp_sign; -> RESP.
//   - RESP: resp_valid[g]=1, data/sign/err stable until resp_ready[g]; on handshake -> IDLE same edge.
//     resp_ready of other bits ignored.
//   - Latency: accept at cycle T -> unit_enable at T+1 -> resp_valid from T+2+UNIT_LAT. Back-to-back: next accept
//     earliest the cycle after response handshake (throughput 1 op per UNIT_LAT+3 cycles min).
//   - Requester dropping req_valid before grant is legal; no grant made for it. Command fields sampled only in accept cycle.
//   - Simultaneous requests: strict rotation; a continuously requesting client waits at most NUM_REQ-1 grants.
//   - Arbiter never modifies operands; all bit arithmetic is in the unit.
// CONFIGURATION
//   BITOP_RANGE_CHECK_EN defined: in accept cycle, if req_op[2]==1 or req_opb >= DATA_W, command is accepted
//     but NOT issued (ISSUE/WAIT skipped, unit_enable stays 0); FSM goes IDLE->RESP next cycle with resp_err=1,
//     resp_data=0, resp_sign=0. Legal commands give resp_err=0.
//   BITOP_RANGE_CHECK_EN undefined: no checking, every command issued unchanged, resp_err tied 0.
// TESTING
//   1. Single req: req1 op=001 opa=0 opb=5 -> unit_enable at T+1, resp_valid=4'b0010 at T+3 (UNIT_LAT=1), resp_data=0x20.
//   2. All 4 valid continuously after reset -> grant order 0,1,2,3,0; each resp_valid one-hot matches granted index.
//   3. Backpressure: resp_ready low 10 cycles -> resp_valid/resp_data stable, req_ready all 0, no unit_enable.
//   4. Reset asserted in WAIT -> next cycle all outputs 0, FSM IDLE; next request granted to req 0 first.
//   5. op=010 opa=0x8000_0000_0000_0000 opb=63 -> resp_data=1, resp_sign per unit_sign; UNIT_LAT=3 -> resp_valid at T+5.
//   6. With BITOP_RANGE_CHECK_EN: opb=64 -> no unit_enable, resp_err=1 at T+1; without: issued, resp_err=0.

Source files
------------

// File: rtl/bitop_req_arbiter.sv
// bitop_req_arbiter
// Round-robin front end that shares one bit-manipulation unit (clr/set/get/pass)
// among NUM_REQ requesters: one command in flight, per-requester registered response.
// Optional feature macro: BITOP_RANGE_CHECK_EN -- when defined, reserved ops
// (op[2]=1) and bit indices >= DATA_W are accepted but answered with resp_err=1
// without touching the unit. When undefined, every command is issued unchanged.
//
// state | meaning
// IDLE  | no command held; grant made combinationally to next valid requester
// ISSUE | unit_enable strobe, latched command on unit_* pins
// WAIT  | latency down-counter running; unit result captured at terminal count
// RESP  | response held on resp_* until the owner's resp_ready
module bitop_req_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 64,
   parameter int UNIT_LAT = 1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [3*NUM_REQ-1:0]      req_op,
   input  logic [DATA_W*NUM_REQ-1:0] req_opa,
   input  logic [DATA_W*NUM_REQ-1:0] req_opb,
   output logic [NUM_REQ-1:0]        resp_valid,
   input  logic [NUM_REQ-1:0]        resp_ready,
   output logic [DATA_W-1:0]         resp_data,
   output logic                      resp_sign,
   output logic                      resp_err,
   output logic                      unit_enable,
   output logic [2:0]                unit_operation,
   output logic [DATA_W-1:0]         unit_opa,
   output logic [DATA_W-1:0]         unit_opb,
   input  logic [DATA_W-1:0]         unit_out,
   input  logic                      unit_sign,
   output logic                      busy
);

   localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = (UNIT_LAT > 1) ? $clog2(UNIT_LAT) : 1;
   localparam logic [GW-1:0]      LAST_INIT = GW'(NUM_REQ - 1);
   localparam logic [CW-1:0]      CNT_LOAD  = CW'(UNIT_LAT - 1);
   localparam logic [NUM_REQ-1:0] ONE_HOT0  = {{(NUM_REQ-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_RESP  = 2'd3
   } state_t;

   state_t            state;
   logic [GW-1:0]     last_grant;
   logic [GW-1:0]     grant_idx;
   logic              grant_found;
   logic [CW-1:0]     lat_cnt;
   logic [2:0]        op_arr  [NUM_REQ];
   logic [DATA_W-1:0] opa_arr [NUM_REQ];
   logic [DATA_W-1:0] opb_arr [NUM_REQ];
   logic [2:0]        sel_op;
   logic [DATA_W-1:0] sel_opa;
   logic [DATA_W-1:0] sel_opb;
   logic              cmd_bad;

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign op_arr[i]  = req_op[3*i +: 3];
      assign opa_arr[i] = req_opa[DATA_W*i +: DATA_W];
      assign opb_arr[i] = req_opb[DATA_W*i +: DATA_W];
   end

   // Rotating priority search: first valid requester after the last one granted.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = last_grant;
      for (int i = 1; i <= NUM_REQ; i++) begin
         if (!grant_found && req_valid[GW'((int'(last_grant) + i) % NUM_REQ)]) begin
            grant_found = 1'b1;
            grant_idx   = GW'((int'(last_grant) + i) % NUM_REQ);
         end
      end
   end

   assign sel_op  = op_arr[grant_idx];
   assign sel_opa = opa_arr[grant_idx];
   assign sel_opb = opb_arr[grant_idx];

`ifdef BITOP_RANGE_CHECK_EN
   localparam logic [DATA_W-1:0] IDX_LIMIT = DATA_W'(DATA_W);
   assign cmd_bad = sel_op[2] | (sel_opb >= IDX_LIMIT);
`else
   assign cmd_bad = 1'b0;
`endif

   // Accept strobe is only offered while idle and out of reset.
   always_comb begin
      req_ready = '0;
      if ((state == ST_IDLE) && !reset && grant_found) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   assign busy = (state != ST_IDLE);

   // Sequencer: accept, issue strobe, latency count, hold response until owner takes it.
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= ST_IDLE;
         last_grant     <= LAST_INIT;
         lat_cnt        <= '0;
         resp_valid     <= '0;
         resp_data      <= '0;
         resp_sign      <= 1'b0;
         resp_err       <= 1'b0;
         unit_enable    <= 1'b0;
         unit_operation <= '0;
         unit_opa       <= '0;
         unit_opb       <= '0;
      end else begin
         unit_enable <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_found) begin
                  last_grant <= grant_idx;
                  if (cmd_bad) begin
                     // Rejected commands never reach the unit; answer straight away.
                     resp_valid <= ONE_HOT0 << grant_idx;
                     resp_data  <= '0;
                     resp_sign  <= 1'b0;
                     resp_err   <= 1'b1;
                     state      <= ST_RESP;
                  end else begin
                     unit_operation <= sel_op;
                     unit_opa       <= sel_opa;
                     unit_opb       <= sel_opb;
                     unit_enable    <= 1'b1;
                     state          <= ST_ISSUE;
                  end
               end
            end
            ST_ISSUE: begin
               lat_cnt <= CNT_LOAD;
               state   <= ST_WAIT;
            end
            ST_WAIT: begin
               if (lat_cnt == '0) begin
                  resp_data  <= unit_out;
                  resp_sign  <= unit_sign;
                  resp_err   <= 1'b0;
                  resp_valid <= ONE_HOT0 << last_grant;
                  state      <= ST_RESP;
               end else begin
                  lat_cnt <= lat_cnt - CW'(1);
               end
            end
            ST_RESP: begin
               if (resp_ready[last_grant]) begin
                  resp_valid <= '0;
                  state      <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bitop_req_arbiter.sv
// Bench for bitop_req_arbiter: a timeline model of the arbiter (grant rotation,
// fixed issue/response offsets from the accept cycle, owner handshake) is
// compared with the DUT every cycle, alongside directed scenarios with literal
// expectations. The bit-op unit itself is modelled here with a fixed latency and
// random garbage on its outputs outside the valid cycle.
module tb_bitop_req_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 64;
   localparam int LAT     = 3;

   logic                      clk = 1'b0;
   logic                      reset;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ-1:0]        req_ready;
   logic [3*NUM_REQ-1:0]      req_op;
   logic [DATA_W*NUM_REQ-1:0] req_opa;
   logic [DATA_W*NUM_REQ-1:0] req_opb;
   logic [NUM_REQ-1:0]        resp_valid;
   logic [NUM_REQ-1:0]        resp_ready;
   logic [DATA_W-1:0]         resp_data;
   logic                      resp_sign;
   logic                      resp_err;
   logic                      unit_enable;
   logic [2:0]                unit_operation;
   logic [DATA_W-1:0]         unit_opa;
   logic [DATA_W-1:0]         unit_opb;
   logic [DATA_W-1:0]         unit_out = '0;
   logic                      unit_sign = 1'b0;
   logic                      busy;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   bitop_req_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .UNIT_LAT(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op(req_op), .req_opa(req_opa), .req_opb(req_opb),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_data(resp_data), .resp_sign(resp_sign), .resp_err(resp_err),
      .unit_enable(unit_enable), .unit_operation(unit_operation),
      .unit_opa(unit_opa), .unit_opb(unit_opb),
      .unit_out(unit_out), .unit_sign(unit_sign), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [63:0] bitop(logic [2:0] op, logic [63:0] a, logic [63:0] b);
      case (op)
         3'd0:    return a & ~(64'd1 << b);
         3'd1:    return a | (64'd1 << b);
         3'd2:    return (a >> b) & 64'd1;
         3'd3:    return a;
         default: return ~a;
      endcase
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cmd(int r, logic [2:0] op, logic [63:0] a, logic [63:0] b);
      req_op[r*3 +: 3]   = op;
      req_opa[r*64 +: 64] = a;
      req_opb[r*64 +: 64] = b;
   endtask

   // Bit-op unit: result valid only in the cycle LAT after the enable cycle.
   int          u_due = -1;
   logic [63:0] u_res;
   always @(negedge clk) begin
      if (unit_enable === 1'b1) begin
         u_res = bitop(unit_operation, unit_opa, unit_opb);
         u_due = cyc + LAT;
      end
      if (cyc == u_due) begin
         unit_out  = u_res;
         unit_sign = u_res[63];
      end else begin
         unit_out  = {$urandom, $urandom};
         unit_sign = 1'($urandom);
      end
   end

   // Reference model: one outstanding command, described by owner and accept cycle.
   int                 m_last = NUM_REQ - 1;
   int                 m_owner = 0;
   int                 m_t = 0;
   int                 m_g;
   int                 m_rs;
   bit                 m_busy = 1'b0;
   bit                 m_err = 1'b0;
   bit                 m_was_idle;
   bit                 e_ue;
   bit                 e_busy;
   logic [NUM_REQ-1:0] e_rr;
   logic [NUM_REQ-1:0] e_rv;
   logic [2:0]         m_op;
   logic [63:0]        m_a;
   logic [63:0]        m_b;
   logic [63:0]        m_exp = '0;

   always @(negedge clk) begin
      if (reset === 1'b1) begin
         m_busy = 1'b0;
         m_last = NUM_REQ - 1;
      end else if (reset === 1'b0) begin
         m_g        = -1;
         m_was_idle = !m_busy;
         if (m_was_idle) begin
            for (int i = 1; i <= NUM_REQ; i++) begin
               if (m_g < 0 && ((req_valid >> ((m_last + i) % NUM_REQ)) & 1) != 0)
                  m_g = (m_last + i) % NUM_REQ;
            end
         end
         e_rr   = (m_g >= 0) ? (NUM_REQ'(1) << m_g) : '0;
         m_rs   = m_err ? m_t + 1 : m_t + 2 + LAT;
         e_ue   = m_busy && !m_err && (cyc == m_t + 1);
         e_rv   = (m_busy && cyc >= m_rs) ? (NUM_REQ'(1) << m_owner) : '0;
         e_busy = m_busy && (cyc > m_t);
         chk("model_req_ready", 64'(req_ready), 64'(e_rr));
         chk("model_unit_enable", 64'(unit_enable), 64'(e_ue));
         chk("model_resp_valid", 64'(resp_valid), 64'(e_rv));
         chk("model_busy", 64'(busy), 64'(e_busy));
         if (m_busy && !m_err && cyc > m_t && cyc <= m_t + 1 + LAT) begin
            chk("model_unit_operation", 64'(unit_operation), 64'(m_op));
            chk("model_unit_opa", unit_opa, m_a);
            chk("model_unit_opb", unit_opb, m_b);
         end
         if (e_rv != '0) begin
            chk("model_resp_data", resp_data, m_exp);
            chk("model_resp_sign", 64'(resp_sign), 64'(m_exp[63]));
            chk("model_resp_err", 64'(resp_err), 64'(m_err));
            if (((resp_ready >> m_owner) & 1) != 0) m_busy = 1'b0;
         end
         if (m_was_idle && m_g >= 0) begin
            m_busy  = 1'b1;
            m_owner = m_g;
            m_t     = cyc;
            m_last  = m_g;
            m_op    = req_op[m_g*3 +: 3];
            m_a     = req_opa[m_g*64 +: 64];
            m_b     = req_opb[m_g*64 +: 64];
            m_err   = 1'b0;
`ifdef BITOP_RANGE_CHECK_EN
            m_err   = m_op[2] || (m_b >= 64'd64);
`endif
            m_exp   = m_err ? 64'd0 : bitop(m_op, m_a, m_b);
         end
      end
   end

   // Grant order as seen on the DUT's req_ready.
   bit rec_en = 1'b0;
   int grants[$];
   always @(negedge clk) begin
      if (rec_en && reset === 1'b0) begin
         for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) grants.push_back(i);
      end
   end

   // Waits for the next response; reports first unit_enable and first resp_valid cycle.
   task automatic wait_resp(output int rc, output int uc);
      rc = -1;
      uc = -1;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk);
         if (unit_enable === 1'b1 && uc < 0) uc = cyc;
         if (resp_valid != '0) begin
            rc = cyc;
            break;
         end
      end
      if (rc < 0) begin
         checks++;
         errors++;
         $display("FAIL wait_resp: no resp_valid within 60 cycles (cycle %0d)", cyc);
      end
   endtask

   task automatic rand_fields();
      for (int r = 0; r < NUM_REQ; r++) begin
         logic [2:0]  op;
         logic [63:0] b;
         op = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         b  = ($urandom_range(0, 9) == 0) ? 64'($urandom_range(64, 200)) : 64'($urandom_range(0, 63));
         set_cmd(r, op, {$urandom, $urandom}, b);
      end
   endtask

   task automatic check_zero_outputs(string tag);
      chk({tag, "_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_resp_valid"}, 64'(resp_valid), 64'd0);
      chk({tag, "_resp_data"}, resp_data, 64'd0);
      chk({tag, "_resp_sign"}, 64'(resp_sign), 64'd0);
      chk({tag, "_resp_err"}, 64'(resp_err), 64'd0);
      chk({tag, "_unit_enable"}, 64'(unit_enable), 64'd0);
      chk({tag, "_unit_operation"}, 64'(unit_operation), 64'd0);
      chk({tag, "_unit_opa"}, unit_opa, 64'd0);
      chk({tag, "_unit_opb"}, unit_opb, 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
   endtask

   int t0, rc, uc;
   int exp_order[5] = '{0, 1, 2, 3, 0};

   initial begin
      reset      = 1'b1;
      req_valid  = '0;
      req_op     = '0;
      req_opa    = '0;
      req_opb    = '0;
      resp_ready = '0;
      repeat (3) step();
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("reset");

      // Single request from requester 1: set bit 5 of zero.
      step();
      set_cmd(1, 3'b001, 64'd0, 64'd5);
      req_valid  = 4'b0010;
      resp_ready = 4'b1111;
      @(negedge clk);
      t0 = cyc;
      chk("t1_grant", 64'(req_ready), 64'h2);
      step();
      req_valid = '0;
      wait_resp(rc, uc);
      chk("t1_issue_lat", 64'(uc - t0), 64'd1);
      chk("t1_resp_lat", 64'(rc - t0), 64'(2 + LAT));
      chk("t1_resp_valid", 64'(resp_valid), 64'h2);
      chk("t1_resp_data", resp_data, 64'h20);
      repeat (3) step();

      // All requesters valid after reset: strict rotation from requester 0.
      reset = 1'b1;
      step();
      step();
      reset      = 1'b0;
      rec_en     = 1'b1;
      req_valid  = 4'b1111;
      resp_ready = 4'b1111;
      for (int c = 0; c < 200 && grants.size() < 5; c++) begin
         rand_fields();
         step();
      end
      rec_en    = 1'b0;
      req_valid = '0;
      if (grants.size() < 5) begin
         checks++;
         errors++;
         $display("FAIL t2_grant_count: got %0d grants required 5", grants.size());
      end else begin
         for (int i = 0; i < 5; i++) chk($sformatf("t2_grant%0d", i), 64'(grants[i]), 64'(exp_order[i]));
      end
      repeat (10) step();

      // Backpressure: response held while others request and non-owner ready bits toggle.
      set_cmd(2, 3'b001, 64'h0F, 64'd8);
      req_valid  = 4'b0100;
      resp_ready = 4'b0000;
      @(negedge clk);
      t0 = cyc;
      step();
      req_valid = '0;
      wait_resp(rc, uc);
      chk("t3_resp_lat", 64'(rc - t0), 64'(2 + LAT));
      for (int i = 0; i < 10; i++) begin
         step();
         req_valid  = 4'b1111;
         resp_ready = 4'b1011;
         rand_fields();
         @(negedge clk);
         chk("t3_hold_valid", 64'(resp_valid), 64'h4);
         chk("t3_hold_data", resp_data, 64'h10F);
         chk("t3_hold_ready", 64'(req_ready), 64'd0);
         chk("t3_hold_enable", 64'(unit_enable), 64'd0);
      end
      step();
      req_valid  = '0;
      resp_ready = 4'b1111;
      step();
      @(negedge clk);
      chk("t3_released", 64'(resp_valid), 64'd0);
      chk("t3_idle", 64'(busy), 64'd0);
      repeat (2) step();

      // Reset during WAIT aborts the command; rotation restarts at requester 0.
      set_cmd(0, 3'b001, 64'hFF00, 64'd1);
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      @(negedge clk);
      chk("t4_enable", 64'(unit_enable), 64'd1);
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      check_zero_outputs("t4_abort");
      for (int i = 0; i < 8; i++) begin
         step();
         @(negedge clk);
         chk("t4_no_resp", 64'(resp_valid), 64'd0);
      end
      step();
      rand_fields();
      req_valid = 4'b1111;
      @(negedge clk);
      chk("t4_regrant", 64'(req_ready), 64'h1);
      step();
      req_valid = '0;
      repeat (10) step();

      // get of bit 63 with longer unit latency.
      set_cmd(3, 3'b010, 64'h8000_0000_0000_0000, 64'd63);
      req_valid = 4'b1000;
      @(negedge clk);
      t0 = cyc;
      step();
      req_valid = '0;
      wait_resp(rc, uc);
      chk("t5_resp_lat", 64'(rc - t0), 64'd5);
      chk("t5_resp_valid", 64'(resp_valid), 64'h8);
      chk("t5_resp_data", resp_data, 64'd1);
      chk("t5_resp_sign", 64'(resp_sign), 64'd0);
      repeat (3) step();

      // Out-of-range bit index.
      set_cmd(2, 3'b001, 64'd0, 64'd64);
      req_valid = 4'b0100;
      @(negedge clk);
      t0 = cyc;
      step();
      req_valid = '0;
      wait_resp(rc, uc);
`ifdef BITOP_RANGE_CHECK_EN
      chk("t6_no_issue", 64'(uc), 64'hFFFF_FFFF_FFFF_FFFF);
      chk("t6_resp_lat", 64'(rc - t0), 64'd1);
      chk("t6_err", 64'(resp_err), 64'd1);
`else
      chk("t6_issue_lat", 64'(uc - t0), 64'd1);
      chk("t6_resp_lat", 64'(rc - t0), 64'(2 + LAT));
      chk("t6_err", 64'(resp_err), 64'd0);
`endif
      chk("t6_data", resp_data, 64'd0);
      repeat (3) step();

      // Random traffic with occasional reset, checked by the model.
      for (int c = 0; c < 1500; c++) begin
         step();
         reset      = ($urandom_range(0, 399) == 0);
         req_valid  = NUM_REQ'($urandom);
         resp_ready = NUM_REQ'($urandom);
         rand_fields();
      end
      step();
      reset      = 1'b0;
      req_valid  = '0;
      resp_ready = 4'b1111;
      repeat (20) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
